// File: rtl/matriz_scan_driver.sv
// matriz_scan_driver
//
// Double-buffered row-scan driver for a ROWS x COLS LED matrix panel.
// The host fills a back buffer one row at a time. A swap request copies
// the back buffer into the front buffer at the next frame boundary, so a
// displayed frame never mixes old and new content. Each row slot lasts DIV
// cycles, and its first BLANK cycles are dark to suppress ghosting.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   en           scan enable; 0 holds the scan position and darkens the panel
//   wr_en        write wr_data into back-buffer row wr_row on this edge
//   wr_row       back-buffer row index; values >= ROWS are ignored
//   wr_data      row pattern, bit i lights column i
//   swap_req     request a back->front copy at the next frame boundary
//   swap_pending a swap has been requested but not yet applied
//   row_sel      one-hot row enable, all-zero while dark
//   col_data     column pattern of the active row, zero while dark
//   frame_start  one-cycle pulse in the first cycle of each new frame
//
// Handshake: there is no back-pressure. wr_en and swap_req are sampled on
// every rising edge and always take effect on that edge.
//
// Every output is a register loaded from next-state values. The outputs in
// a cycle therefore describe the (row, cnt) position held in that cycle, and
// en takes effect on the outputs from the cycle after the edge that sampled it.
module matriz_scan_driver #(
  parameter int ROWS  = 5,
  parameter int COLS  = 7,
  parameter int DIV   = 1000,
  parameter int BLANK = 8,
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            wr_en,
  input  logic [RW-1:0]   wr_row,
  input  logic [COLS-1:0] wr_data,
  input  logic            swap_req,
  output logic            swap_pending,
  output logic [ROWS-1:0] row_sel,
  output logic [COLS-1:0] col_data,
  output logic            frame_start
);

  // Scan position and buffers
  logic [CW-1:0]   cnt, cnt_n;
  logic [RW-1:0]   row, row_n;
  logic [COLS-1:0] front   [ROWS];
  logic [COLS-1:0] front_n [ROWS];
  logic [COLS-1:0] back    [ROWS];
  logic [COLS-1:0] back_n  [ROWS];
  logic            pending, pending_n;

  // Registered-output next values
  logic [ROWS-1:0] row_sel_n;
  logic [COLS-1:0] col_data_n;
  logic            frame_start_n;

  logic cnt_last;
  logic row_last;
  logic boundary;
  logic lit;

  always_comb begin
    cnt_last = (cnt == CW'(DIV - 1));
    row_last = (row == RW'(ROWS - 1));
    // The frame boundary is the edge that leaves the last slot of the last row.
    boundary = en && cnt_last && row_last;

    cnt_n = cnt;
    row_n = row;
    if (en) begin
      if (cnt_last) begin
        cnt_n = '0;
        row_n = row_last ? '0 : row + 1'b1;
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end

    // The write is merged first, so a swap on the same edge copies it too.
    back_n = back;
    if (wr_en && (int'(wr_row) < ROWS)) begin
      back_n[wr_row] = wr_data;
    end

    // A request arriving on the boundary edge is served immediately and
    // never shows up as pending.
    front_n   = front;
    pending_n = pending;
    if (boundary && (pending || swap_req)) begin
      front_n   = back_n;
      pending_n = 1'b0;
    end else if (swap_req) begin
      pending_n = 1'b1;
    end

    lit        = en && (int'(cnt_n) >= BLANK);
    row_sel_n  = '0;
    col_data_n = '0;
    if (lit) begin
      row_sel_n[row_n] = 1'b1;
      col_data_n       = front_n[row_n];
    end

    frame_start_n = boundary;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      row         <= '0;
      pending     <= 1'b0;
      row_sel     <= '0;
      col_data    <= '0;
      frame_start <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        front[r] <= '0;
        back[r]  <= '0;
      end
    end else begin
      cnt         <= cnt_n;
      row         <= row_n;
      pending     <= pending_n;
      row_sel     <= row_sel_n;
      col_data    <= col_data_n;
      frame_start <= frame_start_n;
      for (int r = 0; r < ROWS; r++) begin
        front[r] <= front_n[r];
        back[r]  <= back_n[r];
      end
    end
  end

  assign swap_pending = pending;

endmodule

// File: tb/tb_matriz_scan_driver.sv
// tb_matriz_scan_driver
//
// Self-checking bench for matriz_scan_driver with ROWS=5, COLS=7, DIV=8 and
// BLANK=2. The reference model tracks the scan as one position inside the
// frame (0 .. ROWS*DIV-1) and keeps both buffers as plain arrays. After each
// rising edge it derives the expected outputs from that position.
module tb_matriz_scan_driver;

  localparam int ROWS  = 5;
  localparam int COLS  = 7;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = ROWS * DIV;

  // Clock/reset and DUT signals
  logic            clk;
  logic            rst;
  logic            en;
  logic            wr_en;
  logic [2:0]      wr_row;
  logic [COLS-1:0] wr_data;
  logic            swap_req;
  logic            swap_pending;
  logic [ROWS-1:0] row_sel;
  logic [COLS-1:0] col_data;
  logic            frame_start;

  matriz_scan_driver #(
    .ROWS(ROWS), .COLS(COLS), .DIV(DIV), .BLANK(BLANK)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_row(wr_row),
    .wr_data(wr_data), .swap_req(swap_req), .swap_pending(swap_pending),
    .row_sel(row_sel), .col_data(col_data), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int              pos;
  logic [COLS-1:0] m_front [ROWS];
  logic [COLS-1:0] m_back  [ROWS];
  bit              m_pend;
  int              cyc;

  int passed;
  int failed;
  int total;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_clear();
    pos    = 0;
    m_pend = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      m_front[r] = '0;
      m_back[r]  = '0;
    end
  endtask

  // One clock edge: update the model with the inputs sampled on that edge,
  // then compare all outputs 1 time unit later.
  task automatic tick();
    bit              en_s;
    bit              bnd;
    int              r;
    int              c;
    logic [ROWS-1:0] exp_rs;
    logic [COLS-1:0] exp_cd;
    @(posedge clk);
    en_s = en;
    bnd  = en && (pos == FRAME - 1);
    if (wr_en && (int'(wr_row) < ROWS)) m_back[wr_row] = wr_data;
    if (bnd && (m_pend || swap_req)) begin
      for (int i = 0; i < ROWS; i++) m_front[i] = m_back[i];
      m_pend = 1'b0;
    end else if (swap_req) begin
      m_pend = 1'b1;
    end
    if (en) pos = (pos + 1) % FRAME;
    cyc++;
    #1;
    r      = pos / DIV;
    c      = pos % DIV;
    exp_rs = '0;
    exp_cd = '0;
    if (en_s && (c >= BLANK)) begin
      exp_rs = ROWS'(1) << r;
      exp_cd = m_front[r];
    end
    check("row_sel", 32'(row_sel), 32'(exp_rs));
    check("col_data", 32'(col_data), 32'(exp_cd));
    check("frame_start", 32'(frame_start), 32'(bnd));
    check("swap_pending", 32'(swap_pending), 32'(m_pend));
  endtask

  task automatic run_to(input int n);
    for (int i = 0; i < 100000 && cyc < n; i++) tick();
  endtask

  // Asynchronous reset pulse in mid-cycle. The outputs are checked while
  // reset is still high, and the release happens just after an edge, so the
  // next cycle is cycle 0.
  task automatic reset_pulse();
    #2;
    rst = 1'b1;
    #1;
    check("rst_row_sel", 32'(row_sel), 32'h0);
    check("rst_col_data", 32'(col_data), 32'h0);
    check("rst_frame_start", 32'(frame_start), 32'h0);
    check("rst_swap_pending", 32'(swap_pending), 32'h0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    passed = 0;
    failed = 0;
    total  = 0;
    cyc    = 0;
    rst    = 1'b1;
    en     = 1'b1;
    wr_en  = 1'b0;
    wr_row = '0;
    wr_data = '0;
    swap_req = 1'b0;
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_row_sel", 32'(row_sel), 32'h0);
    check("reset_col_data", 32'(col_data), 32'h0);
    check("reset_swap_pending", 32'(swap_pending), 32'h0);

    // Idle scan with empty buffers
    run_to(40);
    check("idle_fs40", 32'(frame_start), 32'h1);
    run_to(41);
    check("idle_fs41", 32'(frame_start), 32'h0);
    run_to(130);

    // Load the back buffer, then swap with a request in cycle 10
    reset_pulse();
    for (int k = 0; k < ROWS; k++) begin
      wr_en   = 1'b1;
      wr_row  = 3'(k);
      wr_data = COLS'(1) << k;
      tick();
    end
    wr_en = 1'b0;
    run_to(10);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    check("swap_pend11", 32'(swap_pending), 32'h1);
    run_to(39);
    check("swap_pend39", 32'(swap_pending), 32'h1);
    run_to(40);
    check("swap_pend40", 32'(swap_pending), 32'h0);
    check("dark40", 32'(row_sel), 32'h0);
    run_to(42);
    check("row0_sel42", 32'(row_sel), 32'h01);
    check("row0_col42", 32'(col_data), 32'h01);
    run_to(47);
    check("row0_col47", 32'(col_data), 32'h01);
    run_to(49);
    check("dark49", 32'(row_sel), 32'h0);
    run_to(50);
    check("row1_sel50", 32'(row_sel), 32'h02);
    check("row1_col50", 32'(col_data), 32'h02);

    // Swap request and write on the boundary edge at the end of cycle 79
    run_to(79);
    swap_req = 1'b1;
    wr_en    = 1'b1;
    wr_row   = 3'd3;
    wr_data  = 7'h7f;
    tick();
    swap_req = 1'b0;
    wr_en    = 1'b0;
    check("boundary_no_pend", 32'(swap_pending), 32'h0);
    run_to(106);
    check("row3_sel106", 32'(row_sel), 32'h08);
    check("row3_col106", 32'(col_data), 32'h7f);

    // Scan disabled for 20 cycles in the middle of a row-0 slot, with a
    // swap pending
    run_to(122);
    wr_en   = 1'b1;
    wr_row  = 3'd0;
    wr_data = 7'h55;
    tick();
    wr_en    = 1'b0;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    en       = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("en_off_row_sel", 32'(row_sel), 32'h0);
      check("en_off_col_data", 32'(col_data), 32'h0);
      check("en_off_pending", 32'(swap_pending), 32'h1);
    end
    en = 1'b1;
    run_to(180);
    check("en_resume_fs180", 32'(frame_start), 32'h1);
    run_to(182);
    check("en_resume_col182", 32'(col_data), 32'h55);

    // Out-of-range row writes followed by a swap
    wr_en   = 1'b1;
    wr_row  = 3'd5;
    wr_data = 7'h6a;
    tick();
    wr_row  = 3'd7;
    wr_data = 7'h33;
    tick();
    wr_en    = 1'b0;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    for (int k = 0; k < 2 * FRAME; k++) tick();

    // Randomized traffic
    for (int k = 0; k < 800; k++) begin
      en       = ($urandom_range(0, 9) != 0);
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_row   = 3'($urandom_range(0, 7));
      wr_data  = 7'($urandom);
      swap_req = ($urandom_range(0, 29) == 0);
      tick();
    end
    en       = 1'b1;
    wr_en    = 1'b0;
    swap_req = 1'b0;

    // Reset while a swap is pending during the row 3 slot
    for (int k = 0; k < 2 * FRAME && pos != 3 * DIV + 2; k++) tick();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    tick();
    check("pend_before_rst", 32'(swap_pending), 32'h1);
    reset_pulse();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    run_to(40);
    check("post_rst_fs40", 32'(frame_start), 32'h1);
    run_to(2 * FRAME + 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
